// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one external SRAM controller between the instruction-fetch port
// (read-only) and the data port (read/write). One request is latched at a time
// and presented to the controller until it answers with s_ready or the
// watchdog gives up. Simultaneous requests are resolved round-robin.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   i_valid/i_addr      fetch request in;  i_ready/i_dtr completion out
//   d_valid/d_rw/d_addr/d_dtw  data request in; d_ready/d_dtr completion out
//   err                 qualifies i_ready/d_ready: transaction was aborted
//   s_valid/s_rw/s_addr/s_dtw  request to the SRAM controller
//   s_dtr/s_ready       read data and completion pulse from the controller
//
// TIMEOUT: cycles a grant may wait for s_ready before abort; 0 disables.
module sram_arbiter #(
    parameter int unsigned TIMEOUT = 32'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_dtr,
    input  logic        d_valid,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_dtw,
    output logic        d_ready,
    output logic [31:0] d_dtr,
    output logic        err,
    output logic        s_valid,
    output logic        s_rw,
    output logic [31:0] s_addr,
    output logic [31:0] s_dtw,
    input  logic [31:0] s_dtr,
    input  logic        s_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic        LAST_I  = 1'b0;
    localparam logic        LAST_D  = 1'b1;
    localparam logic        WD_EN   = (TIMEOUT != 32'd0);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT) - 32'd1;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [31:0] cnt_q, cnt_d;
    logic        s_valid_q, s_valid_d;
    logic        s_rw_q, s_rw_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_dtw_q, s_dtw_d;
    logic        i_ready_q, i_ready_d;
    logic [31:0] i_dtr_q, i_dtr_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] d_dtr_q, d_dtr_d;
    logic        err_q, err_d;

    logic        grant_i_s, grant_d_s, in_grant_s, done_s, abort_s;

    // Arbitration and completion decode shared by the next-state and output logic.
    always_comb begin
        // On a tie the port that was not served last wins.
        grant_d_s  = d_valid && (!i_valid || (last_q == LAST_I));
        grant_i_s  = i_valid && !grant_d_s;
        in_grant_s = (state_q == GRANT_I) || (state_q == GRANT_D);
        done_s     = in_grant_s && s_ready;
        // Completion in the same cycle as the timeout takes priority.
        abort_s    = in_grant_s && !s_ready && WD_EN && (cnt_q == WD_LAST);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= LAST_I;
            cnt_q     <= 32'd0;
            s_valid_q <= 1'b0;
            s_rw_q    <= 1'b0;
            s_addr_q  <= 32'd0;
            s_dtw_q   <= 32'd0;
            i_ready_q <= 1'b0;
            i_dtr_q   <= 32'd0;
            d_ready_q <= 1'b0;
            d_dtr_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            s_valid_q <= s_valid_d;
            s_rw_q    <= s_rw_d;
            s_addr_q  <= s_addr_d;
            s_dtw_q   <= s_dtw_d;
            i_ready_q <= i_ready_d;
            i_dtr_q   <= i_dtr_d;
            d_ready_q <= d_ready_d;
            d_dtr_q   <= d_dtr_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d_s) begin
                    state_d = GRANT_D;
                end else if (grant_i_s) begin
                    state_d = GRANT_I;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                if (done_s || abort_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        last_d    = last_q;
        cnt_d     = cnt_q;
        s_valid_d = 1'b0;
        s_rw_d    = s_rw_q;
        s_addr_d  = s_addr_q;
        s_dtw_d   = s_dtw_q;
        i_ready_d = 1'b0;
        i_dtr_d   = i_dtr_q;
        d_ready_d = 1'b0;
        d_dtr_d   = d_dtr_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 32'd0;
                if (grant_d_s) begin
                    s_valid_d = 1'b1;
                    s_rw_d    = d_rw;
                    s_addr_d  = d_addr;
                    s_dtw_d   = d_dtw;
                end else if (grant_i_s) begin
                    s_valid_d = 1'b1;
                    s_rw_d    = 1'b0;
                    s_addr_d  = i_addr;
                end else begin
                    s_valid_d = 1'b0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (done_s || abort_s) begin
                    cnt_d  = 32'd0;
                    err_d  = abort_s;
                    last_d = (state_q == GRANT_D) ? LAST_D : LAST_I;
                    if (state_q == GRANT_I) begin
                        i_ready_d = 1'b1;
                        i_dtr_d   = done_s ? s_dtr : 32'd0;
                    end else begin
                        d_ready_d = 1'b1;
                        d_dtr_d   = done_s ? s_dtr : 32'd0;
                    end
                end else begin
                    s_valid_d = 1'b1;
                    cnt_d     = cnt_q + 32'd1;
                end
            end
            default: begin
                cnt_d = 32'd0;
            end
        endcase
    end

    assign s_valid = s_valid_q;
    assign s_rw    = s_rw_q;
    assign s_addr  = s_addr_q;
    assign s_dtw   = s_dtw_q;
    assign i_ready = i_ready_q;
    assign i_dtr   = i_dtr_q;
    assign d_ready = d_ready_q;
    assign d_dtr   = d_dtr_q;
    assign err     = err_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single external SRAM controller (`ext_sram`) between the CPU instruction-fetch port (read-only) and the data port (read/write). It latches one request at a time, drives the controller's valid/rw/address/write-data handshake, and returns read data and a one-cycle ready pulse to the winning requester. Fair round-robin selection resolves simultaneous requests, and a watchdog aborts a transaction that never completes. It sits between the core's fetch/load-store units and `ext_sram`.

## Interface
- `TIMEOUT`, 64: cycles a granted transaction may wait for `s_ready` before abort; 0 disables the watchdog.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `i_valid`  in  1  fetch request; held high until `i_ready`.
- `i_addr`  in  32  fetch address.
- `i_ready`  out  1  one-cycle completion pulse to the fetch port.
- `i_dtr`  out  32  fetch read data; valid while `i_ready`=1.
- `d_valid`  in  1  data request; held high until `d_ready`.
- `d_rw`  in  1  0 = read, 1 = write.
- `d_addr`  in  32  data address.
- `d_dtw`  in  32  write data.
- `d_ready`  out  1  one-cycle completion pulse to the data port.
- `d_dtr`  out  32  read data; valid while `d_ready`=1 and `d_rw`=0.
- `err`  out  1  asserted with `i_ready`/`d_ready` when the transaction was aborted by the watchdog.
- `s_valid`  out  1  to `ext_sram.valid`.
- `s_rw`  out  1  to `ext_sram.rw`.
- `s_addr`  out  32  to `ext_sram.addri`.
- `s_dtw`  out  32  to `ext_sram.dtw`.
- `s_dtr`  in  32  from `ext_sram.dtr`.
- `s_ready`  in  1  from `ext_sram.ready`; one-cycle completion pulse.

## Operation
- All outputs registered. Reset values: every output 0; state IDLE; `last` = I (so data port wins the first tie); watchdog counter 0.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE: `s_valid`=0; `s_ready` ignored. If only `i_valid`: latch `i_addr`, `s_rw`=0 → GRANT_I. If only `d_valid`: latch `d_rw/d_addr/d_dtw` → GRANT_D. Both: grant the port ≠ `last`. Neither: stay.
- GRANT_x: `s_valid`=1, `s_rw/s_addr/s_dtw` held constant from latch (requester changes ignored). Counter increments each cycle `s_ready`=0.
  - `s_ready`=1: capture `s_dtr` into `x_dtr`, pulse `x_ready`, `err`=0, `s_valid`→0, `last`←x, counter←0, → IDLE.
  - Counter reaches `TIMEOUT`-1 with `s_ready`=0 (TIMEOUT≠0): `x_dtr`←0, pulse `x_ready` with `err`=1, `s_valid`→0, `last`←x, → IDLE.
  - `s_ready` in the same cycle as timeout: completion wins, `err`=0.
- For writes, `d_dtr` carries `s_dtr` as captured (don't-care to consumer).
- `x_dtr` holds its value until the next completion on that port; `x_ready`/`err` are single-cycle.
- Mandatory one IDLE cycle between transactions gives the requester the cycle after `x_ready` to drop or change `valid`; a `valid` still high in that IDLE cycle is a new request.
- Reset asserted mid-transaction: all outputs and state clear immediately (asynchronous); in-flight transaction is abandoned, no ready pulse.

## Timing
- Request seen in IDLE at cycle 0 → `s_valid`=1 from cycle 1.
- `s_ready` at cycle k → `x_ready`=1, `x_dtr` valid in cycle k+1; `s_valid`=0 in k+1; IDLE in k+1; next grant `s_valid` earliest k+2.
- Minimum occupancy per transaction: grant + controller latency + 1 IDLE.
- Watchdog: with TIMEOUT=T, `s_valid` high for exactly T cycles, abort pulse in cycle T+1 after grant.
- Reset release: first request sampled on the first rising edge with `reset`=1.

## Test plan
- Single fetch: `i_valid`=1, `i_addr`=0xAAAA_AAA1; model returns `s_dtr`=0xABCD_1234 after 3 cycles → `s_addr`=0xAAAA_AAA1, `s_rw`=0, `i_ready` 1-cycle pulse with `i_dtr`=0xABCD_1234, `d_ready` stays 0.
- Data write: `d_rw`=1, `d_addr`=0x0000_0100, `d_dtw`=0x1234_5678 → `s_rw`=1, `s_dtw`=0x1234_5678 held until `s_ready`; `d_ready` next cycle, `err`=0.
- Contention: both valid continuously out of reset → grants alternate D, I, D, I; each grant separated by one IDLE cycle; no starvation over 8 transactions.
- Request change during grant: change `d_addr` while GRANT_D → `s_addr` unchanged until completion.
- Watchdog: TIMEOUT=4, model never asserts `s_ready` → `s_valid` high 4 cycles, then `i_ready`=1, `err`=1, `i_dtr`=0; next request serviced normally.
- Reset mid-transaction: drop `reset` while `s_valid`=1 → `s_valid`, `i_ready`, `d_ready`, `err` 0 immediately; after release, first tie grants data port.
